rxcmp_swap_ctrl: RTL and testbench

RXCMP_SWAP_CTRL -- requirements
Module: rxcmp_swap_ctrl

---
 rtl/rxcmp_swap_pkg.sv | 41 ++++
 rtl/rxcmp_swap_ctrl_if.sv | 31 +++
 rtl/swap_dwell_timer.sv | 38 +++
 rtl/rxcmp_swap_ctrl.sv | 154 +++++++++++++++
 tb/tb_rxcmp_swap_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rxcmp_swap_pkg.sv
// Shared types for the rx comparator swap controller: FSM states,
// the comparator-pair output bundle and default counter widths.
package rxcmp_swap_pkg;

  localparam int STEP_W_DEFAULT = 8;
  localparam int HOLD_W_DEFAULT = 16;

  typedef enum logic [4:0] {
    OFF,
    UP_A_PC,
    UP_A_EN,
    A_ACT,
    AB_PC,
    AB_EN,
    AB_SEL,
    AB_DIS,
    AB_PRE,
    B_ACT,
    BA_PC,
    BA_EN,
    BA_SEL,
    BA_DIS,
    BA_PRE,
    DN_DIS,
    DN_PRE
  } state_t;

  // Precharge/enable pins for both comparators plus the output mux select
  typedef struct packed {
    logic a_pc;
    logic a_en;
    logic b_pc;
    logic b_en;
    logic sel_a;
  } pair_out_t;

  function automatic logic is_active(state_t s);
    return (s == A_ACT) || (s == B_ACT);
  endfunction

endpackage

// File: rtl/rxcmp_swap_ctrl_if.sv
// Control/status bundle between a host and the comparator swap controller.
interface rxcmp_swap_ctrl_if import rxcmp_swap_pkg::*; #(
  parameter int STEP_W = STEP_W_DEFAULT,
  parameter int HOLD_W = HOLD_W_DEFAULT
);

  logic              en;
  logic              auto_mode;
  logic              swap_req;
  logic [STEP_W-1:0] step_cycles;
  logic [HOLD_W-1:0] hold_cycles;
  logic              a_pc;
  logic              a_en;
  logic              b_pc;
  logic              b_en;
  logic              sel_a;
  logic              busy;
  logic              active_a;
  logic              swap_done;

  modport master (
    output en, auto_mode, swap_req, step_cycles, hold_cycles,
    input  a_pc, a_en, b_pc, b_en, sel_a, busy, active_a, swap_done
  );

  modport slave (
    input  en, auto_mode, swap_req, step_cycles, hold_cycles,
    output a_pc, a_en, b_pc, b_en, sel_a, busy, active_a, swap_done
  );

endinterface

// File: rtl/swap_dwell_timer.sv
// Saturating down-counter used for both the per-step dwell and the
// active-state hold time. Loading N-1 makes the expire flag rise on the
// N-th cycle after the load.
module swap_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins; otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rxcmp_swap_ctrl.sv
// Sequences a redundant rx comparator pair: bring-up of A, make-before-break
// swaps between A and B (periodic or on request), and orderly takedown.
// Every output is a flop whose next value is decoded from the next state,
// so the outputs always reflect the current state.
module rxcmp_swap_ctrl import rxcmp_swap_pkg::*; #(
  parameter int STEP_W = STEP_W_DEFAULT,
  parameter int HOLD_W = HOLD_W_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  rxcmp_swap_ctrl_if.slave bus
);

  localparam int CNT_W = (HOLD_W > STEP_W) ? HOLD_W : STEP_W;

  state_t     state_q;
  state_t     state_d;
  pair_out_t  pair_q;
  pair_out_t  pair_d;
  logic       busy_q;
  logic       busy_d;
  logic       active_a_q;
  logic       active_a_d;
  logic       swap_done_q;
  logic       swap_done_d;

  logic             tmr_load;
  logic             tmr_expired;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] step_ext;
  logic [CNT_W-1:0] hold_ext;
  logic             swap_go;

  // A swap is due either on hold expiry (auto) or on a sampled request (manual)
  always_comb begin
    swap_go = bus.auto_mode ? tmr_expired : bus.swap_req;
  end

  // Next-state logic; transitional states advance when their dwell expires
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (bus.en) state_d = UP_A_PC;
      UP_A_PC: if (tmr_expired) state_d = UP_A_EN;
      UP_A_EN: if (tmr_expired) state_d = A_ACT;
      A_ACT: begin
        if (!bus.en) begin
          state_d = DN_DIS;
        end else if (swap_go) begin
          state_d = AB_PC;
        end
      end
      AB_PC:   if (tmr_expired) state_d = AB_EN;
      AB_EN:   if (tmr_expired) state_d = AB_SEL;
      AB_SEL:  if (tmr_expired) state_d = AB_DIS;
      AB_DIS:  if (tmr_expired) state_d = AB_PRE;
      AB_PRE:  if (tmr_expired) state_d = B_ACT;
      B_ACT: begin
        if (!bus.en) begin
          state_d = DN_DIS;
        end else if (swap_go) begin
          state_d = BA_PC;
        end
      end
      BA_PC:   if (tmr_expired) state_d = BA_EN;
      BA_EN:   if (tmr_expired) state_d = BA_SEL;
      BA_SEL:  if (tmr_expired) state_d = BA_DIS;
      BA_DIS:  if (tmr_expired) state_d = BA_PRE;
      BA_PRE:  if (tmr_expired) state_d = A_ACT;
      DN_DIS:  if (tmr_expired) state_d = DN_PRE;
      DN_PRE:  if (tmr_expired) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  // Reload the timer on every state change with the dwell of the new state;
  // zero is treated as one cycle, hence the load of max(N,1)-1
  always_comb begin
    step_ext = CNT_W'(bus.step_cycles);
    hold_ext = CNT_W'(bus.hold_cycles);
    tmr_load = (state_d != state_q);
    if (is_active(state_d)) begin
      tmr_load_val = (hold_ext == '0) ? '0 : hold_ext - CNT_W'(1);
    end else begin
      tmr_load_val = (step_ext == '0) ? '0 : step_ext - CNT_W'(1);
    end
  end

  swap_dwell_timer #(
    .W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  // Output decode of the next state; takedown states keep the current mux side
  always_comb begin
    pair_d = pair_q;
    case (state_d)
      OFF:     pair_d = pair_out_t'(5'b10101);
      UP_A_PC: pair_d = pair_out_t'(5'b00101);
      UP_A_EN: pair_d = pair_out_t'(5'b01101);
      A_ACT:   pair_d = pair_out_t'(5'b01101);
      AB_PC:   pair_d = pair_out_t'(5'b01001);
      AB_EN:   pair_d = pair_out_t'(5'b01011);
      AB_SEL:  pair_d = pair_out_t'(5'b01010);
      AB_DIS:  pair_d = pair_out_t'(5'b00010);
      AB_PRE:  pair_d = pair_out_t'(5'b10010);
      B_ACT:   pair_d = pair_out_t'(5'b10010);
      BA_PC:   pair_d = pair_out_t'(5'b00010);
      BA_EN:   pair_d = pair_out_t'(5'b01010);
      BA_SEL:  pair_d = pair_out_t'(5'b01011);
      BA_DIS:  pair_d = pair_out_t'(5'b01001);
      BA_PRE:  pair_d = pair_out_t'(5'b01101);
      DN_DIS:  pair_d = pair_q.sel_a ? pair_out_t'(5'b00101) : pair_out_t'(5'b10000);
      DN_PRE:  pair_d = pair_out_t'({4'b1010, pair_q.sel_a});
      default: pair_d = pair_out_t'(5'b10101);
    endcase
    busy_d      = (state_d != OFF) && !is_active(state_d);
    active_a_d  = (state_d == A_ACT);
    swap_done_d = ((state_d == A_ACT) && (state_q == BA_PRE)) ||
                  ((state_d == B_ACT) && (state_q == AB_PRE));
  end

  // State and output registers with synchronous reset to the OFF values
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OFF;
      pair_q      <= pair_out_t'(5'b10101);
      busy_q      <= 1'b0;
      active_a_q  <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_q      <= pair_d;
      busy_q      <= busy_d;
      active_a_q  <= active_a_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign bus.a_pc      = pair_q.a_pc;
  assign bus.a_en      = pair_q.a_en;
  assign bus.b_pc      = pair_q.b_pc;
  assign bus.b_en      = pair_q.b_en;
  assign bus.sel_a     = pair_q.sel_a;
  assign bus.busy      = busy_q;
  assign bus.active_a  = active_a_q;
  assign bus.swap_done = swap_done_q;

endmodule

// File: tb/tb_rxcmp_swap_ctrl.sv
// Self-checking bench for rxcmp_swap_ctrl. The reference model is a
// schedule of output phases (pin pattern + kind) built from the state table;
// each phase's dwell is taken from step/hold at the moment it is entered.
module tb_rxcmp_swap_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rxcmp_swap_ctrl_if #(.STEP_W(8), .HOLD_W(16)) bus ();

  rxcmp_swap_ctrl #(
    .STEP_W (8),
    .HOLD_W (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [1:0] K_OFF  = 2'd0;
  localparam logic [1:0] K_TR   = 2'd1;
  localparam logic [1:0] K_ACTA = 2'd2;
  localparam logic [1:0] K_ACTB = 2'd3;

  localparam logic [7:0] RESET_VEC = 8'b10101_000;

  typedef struct packed {
    logic [4:0] pins;
    logic [1:0] kind;
    logic       inv;
    logic       done;
  } phase_t;

  phase_t cur;
  phase_t plan[$];
  int     rem;
  int     act_cnt;
  int     hold_lim;

  function automatic phase_t ph(logic [4:0] pins, logic [1:0] kind, logic inv, logic done);
    phase_t p;
    p.pins = pins;
    p.kind = kind;
    p.inv  = inv;
    p.done = done;
    return p;
  endfunction

  function automatic int dwell(int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.a_pc, bus.a_en, bus.b_pc, bus.b_en, bus.sel_a,
            bus.busy, bus.active_a, bus.swap_done};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {cur.pins, cur.kind == K_TR, cur.kind == K_ACTA, cur.done};
  endfunction

  task automatic model_enter(phase_t p);
    cur = p;
    if (p.kind == K_TR) begin
      rem = dwell(int'(bus.step_cycles));
    end else if (p.kind != K_OFF) begin
      act_cnt  = 1;
      hold_lim = dwell(int'(bus.hold_cycles));
    end
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample
  task automatic model_edge();
    phase_t nxt;
    if (reset) begin
      plan.delete();
      model_enter(ph(5'b10101, K_OFF, 1'b0, 1'b0));
    end else begin
      case (cur.kind)
        K_OFF: begin
          if (bus.en) begin
            plan.delete();
            plan.push_back(ph(5'b01101, K_TR, 1'b0, 1'b0));
            plan.push_back(ph(5'b01101, K_ACTA, 1'b1, 1'b0));
            model_enter(ph(5'b00101, K_TR, 1'b0, 1'b0));
          end
        end
        K_TR: begin
          if (rem > 1) begin
            rem--;
          end else begin
            nxt = plan.pop_front();
            model_enter(nxt);
          end
        end
        default: begin
          plan.delete();
          if (!bus.en) begin
            if (cur.kind == K_ACTA) begin
              plan.push_back(ph(5'b10101, K_TR, 1'b0, 1'b0));
              model_enter(ph(5'b00101, K_TR, 1'b0, 1'b0));
            end else begin
              plan.push_back(ph(5'b10100, K_TR, 1'b0, 1'b0));
              model_enter(ph(5'b10000, K_TR, 1'b0, 1'b0));
            end
            plan.push_back(ph(5'b10101, K_OFF, 1'b0, 1'b0));
          end else if (bus.auto_mode ? (act_cnt >= hold_lim) : bus.swap_req) begin
            if (cur.kind == K_ACTA) begin
              plan.push_back(ph(5'b01011, K_TR, 1'b1, 1'b0));
              plan.push_back(ph(5'b01010, K_TR, 1'b1, 1'b0));
              plan.push_back(ph(5'b00010, K_TR, 1'b1, 1'b0));
              plan.push_back(ph(5'b10010, K_TR, 1'b1, 1'b0));
              plan.push_back(ph(5'b10010, K_ACTB, 1'b1, 1'b1));
              model_enter(ph(5'b01001, K_TR, 1'b1, 1'b0));
            end else begin
              plan.push_back(ph(5'b01010, K_TR, 1'b1, 1'b0));
              plan.push_back(ph(5'b01011, K_TR, 1'b1, 1'b0));
              plan.push_back(ph(5'b01001, K_TR, 1'b1, 1'b0));
              plan.push_back(ph(5'b01101, K_TR, 1'b1, 1'b0));
              plan.push_back(ph(5'b01101, K_ACTA, 1'b1, 1'b1));
              model_enter(ph(5'b00010, K_TR, 1'b1, 1'b0));
            end
          end else begin
            act_cnt++;
            cur.done = 1'b0;
          end
        end
      endcase
    end
  endtask

  task automatic step_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic go_reset();
    bus.en = 1'b0;
    bus.swap_req = 1'b0;
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.en = 1'b1;
    bus.auto_mode = 1'b1;
    bus.swap_req = 1'b0;
    bus.step_cycles = 8'd2;
    bus.hold_cycles = 16'd5;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec() !== RESET_VEC) begin
        miscompares++;
        $display("[TB] FAIL reset cyc%0d got %b want %b", i, dut_vec(), RESET_VEC);
      end
    end
    reset = 1'b0;
    bus.en = 1'b0;
  endtask

  task automatic test_bring_up();
    int first_act;
    int done_seen;
    go_reset();
    bus.auto_mode = 1'b0;
    bus.step_cycles = 8'd2;
    bus.hold_cycles = 16'd3;
    bus.en = 1'b1;
    first_act = -1;
    done_seen = 0;
    for (int c = 1; c <= 12; c++) begin
      step_cycle();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL bring_up cyc%0d got %b want %b", c, dut_vec(), exp_vec());
      end
      if (bus.active_a === 1'b1 && first_act < 0) first_act = c;
      if (bus.swap_done === 1'b1) done_seen++;
    end
    vectors++;
    if (first_act != 5) begin
      miscompares++;
      $display("[TB] FAIL bring_up_latency got %0d want 5", first_act);
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL bring_up_swap_done got %0d pulses want 0", done_seen);
    end
  endtask

  task automatic test_auto_swap();
    int act_obs;
    int busy_obs;
    int done_obs;
    int done_at;
    logic inv_ok;
    go_reset();
    bus.auto_mode = 1'b1;
    bus.step_cycles = 8'd2;
    bus.hold_cycles = 16'd5;
    bus.en = 1'b1;
    act_obs = 0;
    busy_obs = 0;
    done_obs = 0;
    done_at = -1;
    for (int c = 1; c <= 24; c++) begin
      step_cycle();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL auto_swap cyc%0d got %b want %b", c, dut_vec(), exp_vec());
      end
      if (cur.inv) begin
        inv_ok = bus.sel_a ? (!bus.a_pc && bus.a_en) : (!bus.b_pc && bus.b_en);
        vectors++;
        if (inv_ok !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL auto_swap_invariant cyc%0d got %b want sel-side enabled", c, dut_vec());
        end
      end
      if (c <= 19 && bus.active_a === 1'b1) act_obs++;
      if (c >= 10 && c <= 19 && bus.busy === 1'b1) busy_obs++;
      if (bus.swap_done === 1'b1) begin
        done_obs++;
        done_at = c;
      end
    end
    vectors++;
    if (act_obs != 5 || busy_obs != 10) begin
      miscompares++;
      $display("[TB] FAIL auto_swap_dwell got A_ACT=%0d swap=%0d want 5 and 10", act_obs, busy_obs);
    end
    vectors++;
    if (done_obs != 1 || done_at != 20) begin
      miscompares++;
      $display("[TB] FAIL auto_swap_done got %0d pulses at %0d want 1 at 20", done_obs, done_at);
    end
  endtask

  task automatic test_manual_swap();
    int done_obs;
    int late_busy;
    go_reset();
    bus.auto_mode = 1'b0;
    bus.step_cycles = 8'd1;
    bus.hold_cycles = 16'd2;
    bus.en = 1'b1;
    done_obs = 0;
    late_busy = 0;
    for (int c = 0; c < 40; c++) begin
      bus.swap_req = (c == 8 || c == 24);
      step_cycle();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL manual_swap cyc%0d got %b want %b", c, dut_vec(), exp_vec());
      end
      if (bus.swap_done === 1'b1) done_obs++;
      if (c >= 30 && bus.busy !== 1'b0) late_busy++;
      if (c == 13) begin
        vectors++;
        if ({bus.swap_done, bus.active_a, bus.sel_a} !== 3'b100) begin
          miscompares++;
          $display("[TB] FAIL manual_to_b got done/act/sel %b want 100",
                   {bus.swap_done, bus.active_a, bus.sel_a});
        end
      end
      if (c == 29) begin
        vectors++;
        if ({bus.swap_done, bus.active_a, bus.sel_a} !== 3'b111) begin
          miscompares++;
          $display("[TB] FAIL manual_to_a got done/act/sel %b want 111",
                   {bus.swap_done, bus.active_a, bus.sel_a});
        end
      end
    end
    bus.swap_req = 1'b0;
    vectors++;
    if (done_obs != 2 || late_busy != 0 || bus.active_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL manual_no_extra got done=%0d late_busy=%0d act=%b want 2 0 1",
               done_obs, late_busy, bus.active_a);
    end
  endtask

  task automatic test_takedown();
    logic dropped;
    logic finished;
    int   b_obs;
    int   dis_obs;
    int   pre_obs;
    go_reset();
    bus.auto_mode = 1'b1;
    bus.step_cycles = 8'd2;
    bus.hold_cycles = 16'd3;
    bus.en = 1'b1;
    dropped = 1'b0;
    finished = 1'b0;
    b_obs = 0;
    dis_obs = 0;
    pre_obs = 0;
    for (int c = 0; c < 60 && !finished; c++) begin
      step_cycle();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL takedown cyc%0d got %b want %b", c, dut_vec(), exp_vec());
      end
      if (dropped) begin
        if (dut_vec() === 8'b10010_001 || dut_vec() === 8'b10010_000) b_obs++;
        if (dut_vec() === 8'b10000_100) dis_obs++;
        if (dut_vec() === 8'b10100_100) pre_obs++;
        if (cur.kind == K_OFF) finished = 1'b1;
      end
      if (!dropped && cur.kind == K_TR && cur.pins == 5'b01010) begin
        bus.en = 1'b0;
        dropped = 1'b1;
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("[TB] FAIL takedown_timeout got no OFF within 60 cycles want OFF");
    end
    vectors++;
    if (b_obs != 1 || dis_obs != 2 || pre_obs != 2) begin
      miscompares++;
      $display("[TB] FAIL takedown_phases got B=%0d DIS=%0d PRE=%0d want 1 2 2", b_obs, dis_obs, pre_obs);
    end
    vectors++;
    if (dut_vec() !== RESET_VEC) begin
      miscompares++;
      $display("[TB] FAIL takedown_off got %b want %b", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_reset_mid_swap();
    logic found;
    go_reset();
    bus.auto_mode = 1'b1;
    bus.step_cycles = 8'd3;
    bus.hold_cycles = 16'd1;
    bus.en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step_cycle();
      if (cur.kind == K_TR && cur.pins == 5'b01011) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_swap_timeout got no AB_EN within 40 cycles want AB_EN");
    end
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    bus.en = 1'b0;
    vectors++;
    if (dut_vec() !== RESET_VEC) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_swap got %b want %b", dut_vec(), RESET_VEC);
    end
    for (int c = 0; c < 3; c++) begin
      step_cycle();
      vectors++;
      if (dut_vec() !== RESET_VEC) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_swap_hold cyc%0d got %b want %b", c, dut_vec(), RESET_VEC);
      end
    end
  endtask

  task automatic test_zero_dwell();
    int done_obs;
    go_reset();
    bus.auto_mode = 1'b1;
    bus.step_cycles = 8'd0;
    bus.hold_cycles = 16'd0;
    bus.en = 1'b1;
    done_obs = 0;
    for (int c = 1; c <= 40; c++) begin
      step_cycle();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL zero_dwell cyc%0d got %b want %b", c, dut_vec(), exp_vec());
      end
      if (bus.swap_done === 1'b1) done_obs++;
    end
    vectors++;
    if (done_obs != 6) begin
      miscompares++;
      $display("[TB] FAIL zero_dwell_swaps got %0d want 6", done_obs);
    end
  endtask

  task automatic test_random();
    logic inv_ok;
    go_reset();
    bus.auto_mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.en = ($urandom % 16) != 0;
      bus.swap_req = ($urandom % 6) == 0;
      if (($urandom % 50) == 0) bus.auto_mode = ~bus.auto_mode;
      if (($urandom % 10) == 0) bus.step_cycles = 8'($urandom % 4);
      if (($urandom % 10) == 0) bus.hold_cycles = 16'($urandom % 8);
      reset = ($urandom % 300) == 0;
      step_cycle();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL random cyc%0d got %b want %b", c, dut_vec(), exp_vec());
      end
      vectors++;
      if ((bus.a_pc && bus.a_en) || (bus.b_pc && bus.b_en)) begin
        miscompares++;
        $display("[TB] FAIL random_pc_en cyc%0d got %b want no pc with en", c, dut_vec());
      end
      if (cur.inv) begin
        inv_ok = bus.sel_a ? (!bus.a_pc && bus.a_en) : (!bus.b_pc && bus.b_en);
        vectors++;
        if (inv_ok !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL random_invariant cyc%0d got %b want sel-side enabled", c, dut_vec());
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.auto_mode = 1'b0;
    bus.swap_req = 1'b0;
    bus.step_cycles = 8'd1;
    bus.hold_cycles = 16'd1;
    cur = ph(5'b10101, K_OFF, 1'b0, 1'b0);
    rem = 0;
    act_cnt = 0;
    hold_lim = 1;
    test_reset();
    test_bring_up();
    test_auto_swap();
    test_manual_swap();
    test_takedown();
    test_reset_mid_swap();
    test_zero_dwell();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
